// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - in-flight branch queue, predictor update, mispredict flush and stats
// Oldest recorded prediction is checked against each EX resolution; a mispredict clears the queue.
module branch_resolver #(
  parameter int IDXW   = 4,
  parameter int QDEPTH = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            fetch_valid,
  input  logic [IDXW-1:0] fetch_index,
  input  logic            fetch_predict,
  input  logic [31:0]     fetch_target,
  input  logic [31:0]     fetch_npc,
  output logic            fetch_ready,
  input  logic            res_valid,
  input  logic            res_taken,
  input  logic [31:0]     res_target,
  output logic            upd_en,
  output logic            upd_taken,
  output logic [IDXW-1:0] upd_index,
  output logic [31:0]     upd_target,
  output logic            flush,
  output logic [31:0]     redirect_pc,
  output logic            q_empty,
  output logic            res_error,
  output logic [31:0]     br_count,
  output logic [31:0]     mp_count
);
  localparam int PW = $clog2(QDEPTH);

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  state_t          r_state;
  logic [PW:0]     r_wptr;
  logic [PW:0]     r_rptr;
  logic [IDXW-1:0] r_idx [QDEPTH];
  logic            r_pred [QDEPTH];
  logic [31:0]     r_tgt [QDEPTH];
  logic [31:0]     r_npc [QDEPTH];

  logic            w_empty;
  logic            w_full;
  logic            w_run;
  logic            w_push;
  logic            w_pop;
  logic            w_err;
  logic            w_mp;
  logic [PW-1:0]   w_head;
  logic [PW-1:0]   w_tail;

  assign w_head  = r_rptr[PW-1:0];
  assign w_tail  = r_wptr[PW-1:0];
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PW] != r_rptr[PW]) && (w_tail == w_head);
  assign w_run   = (r_state == S_RUN);

  assign fetch_ready = !w_full && w_run && !RST;
  assign q_empty     = w_empty;

  assign w_push = fetch_valid && fetch_ready;
  assign w_pop  = res_valid && !w_empty && w_run;
  assign w_err  = res_valid && w_empty && w_run;
  assign w_mp   = (r_pred[w_head] != res_taken) ||
                  (r_pred[w_head] && res_taken && (r_tgt[w_head] != res_target));

  // Record storage carries no reset: validity is defined purely by the pointers.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_idx[w_tail]  <= fetch_index;
      r_pred[w_tail] <= fetch_predict;
      r_tgt[w_tail]  <= fetch_target;
      r_npc[w_tail]  <= fetch_npc;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= S_RUN;
      r_wptr      <= '0;
      r_rptr      <= '0;
      upd_en      <= 1'b0;
      upd_taken   <= 1'b0;
      upd_index   <= '0;
      upd_target  <= '0;
      flush       <= 1'b0;
      redirect_pc <= '0;
      res_error   <= 1'b0;
      br_count    <= '0;
      mp_count    <= '0;
    end else begin
      upd_en    <= 1'b0;
      flush     <= 1'b0;
      res_error <= w_err;
      case (r_state)
        S_RUN: begin
          if (w_pop) begin
            upd_en     <= 1'b1;
            upd_taken  <= res_taken;
            upd_index  <= r_idx[w_head];
            upd_target <= res_taken ? res_target : r_tgt[w_head];
            if (br_count != 32'hFFFF_FFFF) br_count <= br_count + 32'd1;
          end
          // A mispredict squashes every record, including a same-cycle wrong-path push.
          if (w_pop && w_mp) begin
            flush       <= 1'b1;
            redirect_pc <= res_taken ? res_target : r_npc[w_head];
            if (mp_count != 32'hFFFF_FFFF) mp_count <= mp_count + 32'd1;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_state     <= S_FLUSH;
          end else begin
            r_wptr <= r_wptr + {{PW{1'b0}}, w_push};
            r_rptr <= r_rptr + {{PW{1'b0}}, w_pop};
          end
        end
        S_FLUSH: r_state <= S_RUN;
        default: r_state <= S_RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - scoreboard bench for branch_resolver with a queue-based reference model
module tb_branch_resolver;
  localparam int IDXW   = 4;
  localparam int QDEPTH = 4;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            fetch_valid = 1'b0;
  logic [IDXW-1:0] fetch_index = '0;
  logic            fetch_predict = 1'b0;
  logic [31:0]     fetch_target = '0;
  logic [31:0]     fetch_npc = '0;
  logic            fetch_ready;
  logic            res_valid = 1'b0;
  logic            res_taken = 1'b0;
  logic [31:0]     res_target = '0;
  logic            upd_en;
  logic            upd_taken;
  logic [IDXW-1:0] upd_index;
  logic [31:0]     upd_target;
  logic            flush;
  logic [31:0]     redirect_pc;
  logic            q_empty;
  logic            res_error;
  logic [31:0]     br_count;
  logic [31:0]     mp_count;

  branch_resolver #(.IDXW(IDXW), .QDEPTH(QDEPTH)) dut (
    .CLK(CLK), .RST(RST),
    .fetch_valid(fetch_valid), .fetch_index(fetch_index), .fetch_predict(fetch_predict),
    .fetch_target(fetch_target), .fetch_npc(fetch_npc), .fetch_ready(fetch_ready),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .upd_en(upd_en), .upd_taken(upd_taken), .upd_index(upd_index), .upd_target(upd_target),
    .flush(flush), .redirect_pc(redirect_pc), .q_empty(q_empty), .res_error(res_error),
    .br_count(br_count), .mp_count(mp_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [IDXW-1:0] idx;
    logic            pred;
    logic [31:0]     tgt;
    logic [31:0]     npc;
  } rec_t;

  typedef struct {
    logic            upd;
    logic            taken;
    logic [IDXW-1:0] idx;
    logic [31:0]     tgt;
    logic            fl;
    logic [31:0]     redir;
    logic            err;
    logic [31:0]     br;
    logic [31:0]     mp;
  } ev_t;

  int   checks = 0;
  int   errors = 0;
  rec_t mq[$];
  ev_t  exp_q[$];
  bit          m_flush = 1'b0;
  logic [31:0] m_br = '0;
  logic [31:0] m_mp = '0;
  logic [31:0] m_redir = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: any strobe from the DUT must match the oldest expected event.
  always @(negedge CLK) begin
    if (upd_en || flush || res_error) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: upd_en=%0b flush=%0b res_error=%0b with nothing expected at %0t",
                 upd_en, flush, res_error, $time);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("upd_en", {31'd0, upd_en}, {31'd0, e.upd});
        chk("flush", {31'd0, flush}, {31'd0, e.fl});
        chk("res_error", {31'd0, res_error}, {31'd0, e.err});
        chk("redirect_pc", redirect_pc, e.redir);
        chk("br_count", br_count, e.br);
        chk("mp_count", mp_count, e.mp);
        if (e.upd) begin
          chk("upd_taken", {31'd0, upd_taken}, {31'd0, e.taken});
          chk("upd_index", {28'd0, upd_index}, {28'd0, e.idx});
          chk("upd_target", upd_target, e.tgt);
        end
      end
    end
  end

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic step(input bit rst, input bit fv, input logic [IDXW-1:0] idx, input bit pred,
                      input logic [31:0] tgt, input logic [31:0] npc,
                      input bit rv, input bit rt, input logic [31:0] rtgt);
    bit   ready;
    bit   dopush;
    bit   mp;
    rec_t h;
    rec_t r;
    ev_t  e;
    @(negedge CLK);
    chk("q_empty", {31'd0, q_empty}, {31'd0, (mq.size() == 0)});
    RST = rst; fetch_valid = fv; fetch_index = idx; fetch_predict = pred;
    fetch_target = tgt; fetch_npc = npc; res_valid = rv; res_taken = rt; res_target = rtgt;
    #1;
    ready = !rst && !m_flush && (mq.size() < QDEPTH);
    chk("fetch_ready", {31'd0, fetch_ready}, {31'd0, ready});
    dopush = fv && ready;
    r.idx = idx; r.pred = pred; r.tgt = tgt; r.npc = npc;
    if (rst) begin
      mq.delete();
      m_flush = 0; m_br = '0; m_mp = '0; m_redir = '0;
    end else if (m_flush) begin
      m_flush = 0;
    end else if (rv) begin
      e.upd = 0; e.taken = 0; e.idx = '0; e.tgt = '0; e.fl = 0; e.err = 0;
      if (mq.size() == 0) begin
        e.err = 1;
      end else begin
        h = mq.pop_front();
        mp = (h.pred != rt) || (h.pred && rt && (h.tgt != rtgt));
        m_br = sat_inc(m_br);
        e.upd = 1; e.taken = rt; e.idx = h.idx; e.tgt = rt ? rtgt : h.tgt;
        if (mp) begin
          e.fl = 1;
          m_redir = rt ? rtgt : h.npc;
          m_mp = sat_inc(m_mp);
          mq.delete();
          m_flush = 1;
          dopush = 0;
        end
      end
      e.redir = m_redir; e.br = m_br; e.mp = m_mp;
      exp_q.push_back(e);
    end
    if (dopush && !rst) mq.push_back(r);
  endtask

  task automatic idle();
    step(0, 0, '0, 0, '0, '0, 0, 0, '0);
  endtask

  task automatic push(input logic [IDXW-1:0] idx, input bit pred, input logic [31:0] tgt,
                      input logic [31:0] npc);
    step(0, 1, idx, pred, tgt, npc, 0, 0, '0);
  endtask

  task automatic resolve(input bit rt, input logic [31:0] rtgt);
    step(0, 0, '0, 0, '0, '0, 1, rt, rtgt);
  endtask

  initial begin
    step(1, 0, '0, 0, '0, '0, 0, 0, '0);
    step(1, 1, 4'd2, 1, 32'h10, 32'h14, 1, 1, 32'h10);
    @(negedge CLK);
    chk("rst_upd_en", {31'd0, upd_en}, 32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_redirect", redirect_pc, 32'd0);
    chk("rst_res_error", {31'd0, res_error}, 32'd0);
    chk("rst_br_count", br_count, 32'd0);
    chk("rst_mp_count", mp_count, 32'd0);
    chk("rst_q_empty", {31'd0, q_empty}, 32'd1);
    chk("rst_fetch_ready", {31'd0, fetch_ready}, 32'd0);

    // Correct not-taken, then the mispredict flavours.
    push(4'd3, 0, 32'h100, 32'h44); resolve(0, 32'h0); idle();
    push(4'd5, 0, 32'h0, 32'h84);   resolve(1, 32'h200); idle(); idle();
    push(4'd6, 1, 32'h300, 32'h8);  resolve(1, 32'h304); idle(); idle();
    push(4'd7, 1, 32'h300, 32'h90); resolve(0, 32'h0); idle(); idle();

    // Fill, drop the fifth, drain in order.
    for (int i = 0; i < 5; i++) push(4'(8 + i), 1, 32'h1000 + 32'(i), 32'h40 + 32'(i));
    for (int i = 0; i < 4; i++) resolve(1, 32'h1000 + 32'(i));
    idle();

    // Mispredict with wrong-path pushes and a resolve in the flush cycle.
    push(4'd1, 0, 32'h0, 32'h50); push(4'd2, 0, 32'h0, 32'h60);
    step(0, 1, 4'd9, 1, 32'h70, 32'h74, 1, 1, 32'h500);
    step(0, 1, 4'd10, 1, 32'h80, 32'h84, 1, 0, 32'h0);
    idle();

    // Resolve on empty queue.
    resolve(0, 32'h0); idle();

    // Saturation of br_count.
    idle();
    force dut.br_count = 32'hFFFF_FFFF;
    #1 release dut.br_count;
    m_br = 32'hFFFF_FFFF;
    push(4'd4, 0, 32'h20, 32'h24); resolve(0, 32'h0); idle();

    // Reset with records queued.
    push(4'd1, 0, 32'h0, 32'h4); push(4'd2, 0, 32'h0, 32'h8); push(4'd3, 0, 32'h0, 32'hc);
    step(1, 0, '0, 0, '0, '0, 1, 1, 32'h99);
    resolve(1, 32'h99); idle();

    // Randomized traffic biased toward correct resolves.
    for (int n = 0; n < 1500; n++) begin
      bit rst, fv, pred, rv, rt;
      logic [IDXW-1:0] idx;
      logic [31:0] tgt, npc, rtgt;
      rst  = ($urandom_range(0, 99) == 0);
      fv   = ($urandom_range(0, 1) == 1);
      idx  = IDXW'($urandom);
      pred = ($urandom_range(0, 1) == 1);
      tgt  = {$urandom_range(0, 3) == 0 ? 24'($urandom) : 24'h0, 8'($urandom & 32'hFC)};
      npc  = $urandom;
      rv   = ($urandom_range(0, 9) < 4);
      rt   = ($urandom_range(0, 1) == 1);
      rtgt = $urandom;
      if (mq.size() > 0 && $urandom_range(0, 3) != 0) begin
        rt   = mq[0].pred;
        rtgt = mq[0].tgt;
      end
      step(rst, fv, idx, pred, tgt, npc, rv, rt, rtgt);
    end
    step(1, 0, '0, 0, '0, '0, 0, 0, '0);
    idle(); idle(); idle();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_outputs: %0d expected events never seen, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
